// File: rtl/mul_seq_ctrl.sv
// Sequencing stage around the combinational 32x32 multiplier: registers operands,
// holds them for WAIT_CYCLES while the adder chain settles, then captures LO/overflow.
module mul_seq_ctrl #(
  parameter int WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  input  logic        lo_we,
  input  logic [31:0] lo_wdata,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_res,
  input  logic        mul_of,
  output logic [31:0] lo,
  output logic        of,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // WAIT_CYCLES is expected in 1..15 so the reload fits the 4-bit counter.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [31:0] mul_a_reg;
  logic [31:0] mul_b_reg;
  logic [31:0] lo_reg;
  logic        of_reg;
  logic        done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      mul_a_reg <= 32'd0;
      mul_b_reg <= 32'd0;
      lo_reg    <= 32'd0;
      of_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // MTLO lands first; a multiply accepted alongside overwrites it at completion.
          if (lo_we) begin
            lo_reg <= lo_wdata;
          end
          if (start && !flush) begin
            mul_a_reg <= op_a;
            mul_b_reg <= op_b;
            cnt_reg   <= CNT_INIT;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            state_reg <= IDLE;
          end else if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            lo_reg    <= mul_res;
            of_reg    <= mul_of;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Stall is a pure decode of the registered state so issue logic sees no path from start.
  assign busy  = (state_reg == BUSY);
  assign stall = busy;
  assign done  = done_reg;
  assign lo    = lo_reg;
  assign of    = of_reg;
  assign mul_a = mul_a_reg;
  assign mul_b = mul_b_reg;

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencing stage wrapped around the combinational 32x32 array multiplier in the execute stage.
- Upstream: registers the operands and drives them to the multiplier.
- Settle time: holds the operands stable for a fixed, parameterised number of cycles while the long ripple-adder chain settles.
- Downstream: captures the low 32-bit product and the overflow flag into the architectural LO register.
- Pipeline control: provides the stall and done handshakes, plus direct LO write (MTLO) and flush.

## Interface
- WAIT_CYCLES, 4, cycles operands are held before capture; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  issue a multiply; sampled only in IDLE.
- op_a  in  32  multiplicand, sampled with start.
- op_b  in  32  multiplier, sampled with start.
- flush  in  1  pipeline flush; cancels an in-flight multiply.
- lo_we  in  1  MTLO write strobe.
- lo_wdata  in  32  MTLO data.
- mul_a  out  32  registered operand to multiplier a.
- mul_b  out  32  registered operand to multiplier b.
- mul_res  in  32  multiplier result.
- mul_of  in  1  multiplier overflow flag.
- lo  out  32  architectural LO register.
- of  out  1  overflow flag of the last completed multiply.
- busy  out  1  high while in BUSY.
- stall  out  1  equals busy; holds LO consumers.
- done  out  1  one-cycle pulse when lo/of are updated by a multiply.

## Operation
- States: IDLE, BUSY. The counter cnt is 4 bits.
- IDLE with start=1 and flush=0:
  - mul_a<=op_a, mul_b<=op_b.
  - cnt<=WAIT_CYCLES-1.
  - Go to BUSY.
- IDLE with start=1 and flush=1: start is dropped; stay IDLE.
- BUSY with flush=1:
  - Go to IDLE; lo and of unchanged; no done.
  - mul_a and mul_b keep their values.
- BUSY with cnt!=0 and flush=0: cnt<=cnt-1.
- BUSY with cnt==0 and flush=0:
  - lo<=mul_res, of<=mul_of, done<=1.
  - Go to IDLE.
- done is registered and high for exactly one cycle; it is 0 in all other cycles.
- start is ignored while in BUSY. No queueing; the issuer must respect stall.
- mul_a and mul_b change only on an accepted start. They are stable for the whole BUSY window.
- lo_we:
  - Accepted only in IDLE: lo<=lo_wdata; of unchanged.
  - In BUSY, lo_we is ignored.
  - lo_we and an accepted start in the same IDLE cycle: the LO write happens and the multiply is also accepted; the multiply result later overwrites LO.
- lo is read freely at any time. During BUSY it shows the previous value; stall guards consumers.
- Arithmetic: the block performs none. lo is the low 32 bits exactly as produced by the multiplier; no sign handling.

## Timing
- Reset values: state IDLE; cnt=0; mul_a=0; mul_b=0; lo=0; of=0; done=0; busy=0; stall=0.
- rst overrides everything, including mid-BUSY: the next cycle is IDLE with all reset values and no done.
- Sequence for start accepted in cycle 0:
  - Cycles 1..WAIT_CYCLES: busy=1.
  - Capture happens at the end of cycle WAIT_CYCLES.
  - Cycle WAIT_CYCLES+1: done=1, busy=0, and lo/of hold the new values.
- Latency from start to done is WAIT_CYCLES+1 cycles.
- Back-to-back issue: a new start is accepted in the same cycle that done=1, since that cycle is IDLE.
- Throughput is one multiply per WAIT_CYCLES+1 cycles.
- stall and busy are purely registered-state decodes, with no combinational path from start.

## Test plan
- Reset, then 3*5 with WAIT_CYCLES=4, start in cycle 0:
  - busy=1 in cycles 1-4.
  - done=1 in cycle 5 only, with lo=15 and of=0.
  - mul_a=3 and mul_b=5 held in cycles 1-4.
- 0x0001_0000*0x0001_0000, with the multiplier stub forcing mul_of=1 -> lo=0x0000_0000, of=1, done at cycle 5.
- start again in the done cycle with 7*6 -> second done 5 cycles later with lo=42; start pulses in BUSY are ignored (lo not corrupted, mul_a/mul_b unchanged).
- flush in cycle 2 of a 9*9 multiply:
  - IDLE in cycle 3; no done.
  - lo keeps its prior value (42).
  - A subsequent multiply completes normally.
- lo_we with 0xDEAD_BEEF in IDLE -> lo=0xDEAD_BEEF next cycle.
- lo_we during BUSY -> ignored.
- lo_we in the same cycle as start 2*2 -> lo=0xDEAD_BEEF first, then 4 at done.
- rst asserted in cycle 3 of BUSY -> all outputs at reset values the next cycle; no done pulse afterwards.
